// File: rtl/uart_cmd_parser_if.sv
// Signal bundle between the command parser, uart_ctrl and the IIC EEPROM controller.
// The master side is the parser; the slave side is everything it talks to.
interface uart_cmd_parser_if;
  logic [7:0]  rx_dat;
  logic        rx_rdy;
  logic        tx_en;
  logic [7:0]  tx_dat;
  logic        ee_req;
  logic        ee_wr;
  logic [15:0] ee_addr;
  logic [7:0]  ee_wdat;
  logic        ee_done;
  logic [7:0]  ee_rdat;

  modport master (
    input  rx_dat, rx_rdy, ee_done, ee_rdat,
    output tx_en, tx_dat, ee_req, ee_wr, ee_addr, ee_wdat
  );

  modport slave (
    output rx_dat, rx_rdy, ee_done, ee_rdat,
    input  tx_en, tx_dat, ee_req, ee_wr, ee_addr, ee_wdat
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Host command parser: turns 0x55-framed uart bytes into one EEPROM byte access
// and returns a paced status byte (plus read data) through the uart tx port.
module uart_cmd_parser #(
  parameter int TX_GAP     = 2376,
  parameter int RX_TIMEOUT = 50000,
  parameter int GAP_W      = 12,
  parameter int TMO_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_parser_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, CMD, AH, AL, DAT, REQ, WAIT, RSP0, RSP1
  } state_t;

  localparam logic [7:0] SYNC       = 8'h55;
  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;
  localparam logic [7:0] ST_OK      = 8'hAA;
  localparam logic [7:0] ST_BADCMD  = 8'hEE;
  localparam logic [7:0] ST_TIMEOUT = 8'hEF;

  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(TX_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(RX_TIMEOUT);

  state_t           state;
  logic             rx_rdy_q;
  logic             is_wr;
  logic [15:0]      addr;
  logic [7:0]       wdat;
  logic [7:0]       rdat;
  logic [7:0]       status;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic byte_stb;
  logic gap_free;
  logic tmo_active;
  logic tmo_exp;

  assign byte_stb   = bus.rx_rdy & ~rx_rdy_q;
  assign gap_free   = (gap_cnt == '0);
  assign tmo_active = (state == CMD) || (state == AH) || (state == AL) || (state == DAT);
  assign tmo_exp    = tmo_active && (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      // A level already high when reset releases must not look like a new byte.
      rx_rdy_q    <= 1'b1;
      is_wr       <= 1'b0;
      addr        <= '0;
      wdat        <= '0;
      rdat        <= '0;
      status      <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      bus.tx_en   <= 1'b0;
      bus.tx_dat  <= '0;
      bus.ee_req  <= 1'b0;
      bus.ee_wr   <= 1'b0;
      bus.ee_addr <= '0;
      bus.ee_wdat <= '0;
    end else begin
      rx_rdy_q   <= bus.rx_rdy;
      // NOTE: non-blocking defaults first; a later assignment in the case below
      // overrides them for this edge (pulses clear, counters reload).
      bus.tx_en  <= 1'b0;
      bus.ee_req <= 1'b0;
      if (!gap_free) gap_cnt <= gap_cnt - 1'b1;
      if (!tmo_active || byte_stb) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        IDLE: if (byte_stb && bus.rx_dat == SYNC) state <= CMD;

        CMD, AH, AL, DAT: begin
          if (tmo_exp) begin
            status <= ST_TIMEOUT;
            state  <= RSP0;
          end else if (byte_stb) begin
            case (state)
              CMD: begin
                if (bus.rx_dat == CMD_WR || bus.rx_dat == CMD_RD) begin
                  is_wr <= (bus.rx_dat == CMD_WR);
                  state <= AH;
                end else begin
                  status <= ST_BADCMD;
                  state  <= RSP0;
                end
              end
              AH: begin
                addr[15:8] <= bus.rx_dat;
                state      <= AL;
              end
              AL: begin
                addr[7:0] <= bus.rx_dat;
                state     <= is_wr ? DAT : REQ;
              end
              default: begin
                wdat  <= bus.rx_dat;
                state <= REQ;
              end
            endcase
          end
        end

        REQ: begin
          bus.ee_req  <= 1'b1;
          bus.ee_wr   <= is_wr;
          bus.ee_addr <= addr;
          bus.ee_wdat <= wdat;
          state       <= WAIT;
        end

        // Respond in the cycle after ee_done when pacing already allows it.
        WAIT: if (bus.ee_done) begin
          rdat   <= bus.ee_rdat;
          status <= ST_OK;
          if (gap_free) begin
            bus.tx_en  <= 1'b1;
            bus.tx_dat <= ST_OK;
            gap_cnt    <= GAP_RELOAD;
            state      <= is_wr ? IDLE : RSP1;
          end else begin
            state <= RSP0;
          end
        end

        RSP0: if (gap_free) begin
          bus.tx_en  <= 1'b1;
          bus.tx_dat <= status;
          gap_cnt    <= GAP_RELOAD;
          state      <= (status == ST_OK && !is_wr) ? RSP1 : IDLE;
        end

        RSP1: if (gap_free) begin
          bus.tx_en  <= 1'b1;
          bus.tx_dat <= rdat;
          gap_cnt    <= GAP_RELOAD;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
